// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared widths, fetch FSM states and buffer entry type for the fetch front end
package cpu_fetch_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    localparam logic [PC_W-1:0]    DEFAULT_RESET_PC    = 16'h0000;
    localparam logic [PC_W-1:0]    DEFAULT_PC_STEP     = 16'd2;
    localparam logic [INSTR_W-1:0] DEFAULT_HALT_OPCODE = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    // Modulo-2^16 increment: FFFE + 2 wraps to 0000 with no carry out.
    function automatic logic [PC_W-1:0] pc_advance(input logic [PC_W-1:0] pc,
                                                   input logic [PC_W-1:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - 2-entry {instr, pc} FIFO with push, pop, flush and occupancy count
module fetch_skid_buffer
    import cpu_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic         pop_ok;
    logic         push_ok;

    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);
    assign head    = slot0;

    // Vacated slots are cleared so the head reads as zero whenever the buffer is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else if (flush) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= push_entry;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_entry;
                    end
                end
                2'b01: begin
                    if (count == 2'd1) begin
                        slot0 <= '0;
                        count <= 2'd0;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= '0;
                        count <= 2'd1;
                    end
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= push_entry;
                    end else begin
                        slot1 <= push_entry;
                    end
                    count <= count + 2'd1;
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC/FSM fetch front end feeding decode; IFU_HALT_DETECT_EN enables halt detection
module instr_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC    = DEFAULT_RESET_PC,
    parameter logic [PC_W-1:0]    PC_STEP     = DEFAULT_PC_STEP,
    parameter logic [INSTR_W-1:0] HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
    input  logic               Clock,
    input  logic               Reset_n,
    output logic [PC_W-1:0]    Imem_PC,
    input  logic [INSTR_W-1:0] Imem_Instr,
    input  logic               Redirect,
    input  logic [PC_W-1:0]    Redirect_PC,
    output logic [INSTR_W-1:0] Instr,
    output logic [PC_W-1:0]    Instr_PC,
    output logic               Instr_Valid,
    input  logic               Instr_Ready,
    output logic               Halted
);

    fetch_state_e    state;
    logic [PC_W-1:0] pc;
    logic            halted_q;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic [1:0]      count;
    logic [1:0]      cnt_next;
    logic            pop;
    logic            push;
    logic            redirect_take;
    logic            is_halt;

    assign Imem_PC     = pc;
    assign Instr       = head.instr;
    assign Instr_PC    = head.pc;
    assign Instr_Valid = (count != 2'd0);
    assign Halted      = halted_q;

    assign pop           = Instr_Valid && Instr_Ready;
    assign redirect_take = Redirect && (state != ST_BOOT);
    // A pop in the same cycle frees a slot, so a full buffer can still accept the next word.
    assign push          = (state == ST_FETCH) && !redirect_take && ((count != 2'd2) || pop);
    assign push_entry    = '{instr: Imem_Instr, pc: pc};

`ifdef IFU_HALT_DETECT_EN
    assign is_halt = push && (Imem_Instr == HALT_OPCODE);
`else
    logic unused_halt_opcode;
    assign unused_halt_opcode = ^HALT_OPCODE;
    assign is_halt            = 1'b0;
`endif

    always_comb begin
        cnt_next = count;
        if (redirect_take) begin
            cnt_next = 2'd0;
        end else if (push && !pop) begin
            cnt_next = count + 2'd1;
        end else if (!push && pop) begin
            cnt_next = count - 2'd1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= ST_BOOT;
            pc       <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            halted_q <= 1'b0;
            case (state)
                ST_BOOT: begin
                    state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (redirect_take) begin
                        pc <= Redirect_PC;
                    end else if (is_halt) begin
                        // PC parks on the halt word's own address.
                        state <= ST_HALT;
                    end else if (push) begin
                        pc <= pc_advance(pc, PC_STEP);
                    end
                end
                ST_HALT: begin
                    if (redirect_take) begin
                        state <= ST_FETCH;
                        pc    <= Redirect_PC;
                    end else begin
                        halted_q <= (cnt_next == 2'd0);
                    end
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

    fetch_skid_buffer u_buffer (
        .clk        (Clock),
        .rst_n      (Reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_take),
        .head       (head),
        .count      (count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed and randomized checks of instr_fetch_unit against a queue model
`timescale 1ns/1ps
module tb_instr_fetch_unit;

`ifdef IFU_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic [15:0] Imem_PC;
    logic [15:0] Imem_Instr;
    logic        Redirect = 1'b0;
    logic [15:0] Redirect_PC = 16'h0000;
    logic [15:0] Instr;
    logic [15:0] Instr_PC;
    logic        Instr_Valid;
    logic        Instr_Ready = 1'b0;
    logic        Halted;

    logic        halt_on = 1'b0;
    logic [15:0] halt_addr = 16'h0000;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] mq[$];
    logic [15:0] mpc;
    int          mstate;

    always #5 Clock = ~Clock;

    assign Imem_Instr = (halt_on && Imem_PC == halt_addr) ? 16'hFFFF
                                                          : ({Imem_PC[7:0], Imem_PC[15:8]} ^ 16'h5A00);

    instr_fetch_unit dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .Imem_PC     (Imem_PC),
        .Imem_Instr  (Imem_Instr),
        .Redirect    (Redirect),
        .Redirect_PC (Redirect_PC),
        .Instr       (Instr),
        .Instr_PC    (Instr_PC),
        .Instr_Valid (Instr_Valid),
        .Instr_Ready (Instr_Ready),
        .Halted      (Halted)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (halt_on && a == halt_addr) return 16'hFFFF;
        return {a[7:0], a[15:8]} ^ 16'h5A00;
    endfunction

    task automatic model_reset();
        mq.delete();
        mpc = 16'h0000;
        mstate = 0;
    endtask

    // Advance the model by one clock using the current inputs, then take the edge.
    task automatic tick();
        logic [15:0] w;
        if (mstate == 0) begin
            mstate = 1;
        end else if (Redirect) begin
            mq.delete();
            mpc = Redirect_PC;
            mstate = 1;
        end else begin
            if (mq.size() > 0 && Instr_Ready) void'(mq.pop_front());
            if (mstate == 1 && mq.size() < 2) begin
                w = mem_word(mpc);
                mq.push_back({w, mpc});
                if (HALT_EN && w == 16'hFFFF) mstate = 2;
                else mpc = mpc + 16'd2;
            end
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        Redirect = 1'b0;
        Instr_Ready = 1'b0;
        model_reset();
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        model_reset();
        #2;
        n_checks++; if (Imem_PC !== 16'h0000) begin n_fail++; $display("FAIL reset_imem_pc: got %h expected 0000", Imem_PC); end
        n_checks++; if (Instr_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", Instr_Valid); end
        n_checks++; if (Instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h expected 0000", Instr); end
        n_checks++; if (Instr_PC !== 16'h0000) begin n_fail++; $display("FAIL reset_instr_pc: got %h expected 0000", Instr_PC); end
        n_checks++; if (Halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", Halted); end
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        Instr_Ready = 1'b1;
        tick();
        n_checks++; if (Instr_Valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid: got %b expected 0", Instr_Valid); end
        n_checks++; if (Imem_PC !== 16'h0000) begin n_fail++; $display("FAIL boot_imem_pc: got %h expected 0000", Imem_PC); end
    endtask

    task automatic test_stream();
        do_reset();
        Instr_Ready = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++; if (Instr_Valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, Instr_Valid); end
            n_checks++; if (Instr_PC !== 16'(2 * k)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, Instr_PC, 16'(2 * k)); end
            n_checks++; if (Instr !== mem_word(16'(2 * k))) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h expected %h", k, Instr, mem_word(16'(2 * k))); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        Instr_Ready = 1'b0;
        repeat (4) tick();
        n_checks++; if (Imem_PC !== 16'h0004) begin n_fail++; $display("FAIL bp_hold_pc: got %h expected 0004", Imem_PC); end
        Instr_Ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (Instr_Valid !== 1'b1 || Instr_PC !== 16'(2 * k)) begin
                n_fail++; $display("FAIL bp_order[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", k, Instr_Valid, Instr_PC, 16'(2 * k));
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        Instr_Ready = 1'b0;
        tick();
        tick();
        Redirect = 1'b1;
        Redirect_PC = 16'h000A;
        tick();
        Redirect = 1'b0;
        n_checks++; if (Instr_Valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %b expected 0", Instr_Valid); end
        n_checks++; if (Imem_PC !== 16'h000A) begin n_fail++; $display("FAIL redir_imem_pc: got %h expected 000a", Imem_PC); end
        Instr_Ready = 1'b1;
        tick();
        n_checks++; if (Instr_Valid !== 1'b1 || Instr_PC !== 16'h000A) begin n_fail++; $display("FAIL redir_first: got valid=%b pc=%h expected valid=1 pc=000a", Instr_Valid, Instr_PC); end
        tick();
        n_checks++; if (Instr_PC !== 16'h000C) begin n_fail++; $display("FAIL redir_second: got %h expected 000c", Instr_PC); end
    endtask

    task automatic test_wrap();
        Redirect = 1'b1;
        Redirect_PC = 16'hFFFE;
        tick();
        Redirect = 1'b0;
        n_checks++; if (Instr_Valid !== 1'b0) begin n_fail++; $display("FAIL wrap_flush: got %b expected 0", Instr_Valid); end
        tick();
        n_checks++; if (Instr_PC !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_first: got %h expected fffe", Instr_PC); end
        n_checks++; if (Imem_PC !== 16'h0000) begin n_fail++; $display("FAIL wrap_imem_pc: got %h expected 0000", Imem_PC); end
        tick();
        n_checks++; if (Instr_PC !== 16'h0000) begin n_fail++; $display("FAIL wrap_second: got %h expected 0000", Instr_PC); end
    endtask

    task automatic test_halt();
        do_reset();
        halt_on = 1'b1;
        halt_addr = 16'h0006;
        Instr_Ready = 1'b1;
        repeat (5) tick();
        n_checks++; if (Instr_PC !== 16'h0006 || Instr !== 16'hFFFF) begin n_fail++; $display("FAIL halt_word: got pc=%h instr=%h expected pc=0006 instr=ffff", Instr_PC, Instr); end
`ifdef IFU_HALT_DETECT_EN
        n_checks++; if (Imem_PC !== 16'h0006) begin n_fail++; $display("FAIL halt_pc_hold: got %h expected 0006", Imem_PC); end
        tick();
        n_checks++; if (Halted !== 1'b1 || Instr_Valid !== 1'b0) begin n_fail++; $display("FAIL halt_drained: got halted=%b valid=%b expected halted=1 valid=0", Halted, Instr_Valid); end
        tick();
        n_checks++; if (Imem_PC !== 16'h0006 || Halted !== 1'b1) begin n_fail++; $display("FAIL halt_stays: got pc=%h halted=%b expected pc=0006 halted=1", Imem_PC, Halted); end
        Redirect = 1'b1;
        Redirect_PC = 16'h0000;
        tick();
        Redirect = 1'b0;
        n_checks++; if (Halted !== 1'b0 || Imem_PC !== 16'h0000) begin n_fail++; $display("FAIL halt_exit: got halted=%b pc=%h expected halted=0 pc=0000", Halted, Imem_PC); end
        tick();
        n_checks++; if (Instr_Valid !== 1'b1 || Instr_PC !== 16'h0000) begin n_fail++; $display("FAIL halt_resume: got valid=%b pc=%h expected valid=1 pc=0000", Instr_Valid, Instr_PC); end
`else
        n_checks++; if (Imem_PC !== 16'h0008) begin n_fail++; $display("FAIL nohalt_pc: got %h expected 0008", Imem_PC); end
        tick();
        n_checks++; if (Instr_PC !== 16'h0008 || Halted !== 1'b0) begin n_fail++; $display("FAIL nohalt_next: got pc=%h halted=%b expected pc=0008 halted=0", Instr_PC, Halted); end
`endif
        halt_on = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        Instr_Ready = 1'b0;
        repeat (3) tick();
        n_checks++; if (Imem_PC !== 16'h0004) begin n_fail++; $display("FAIL rmid_full: got %h expected 0004", Imem_PC); end
        Reset_n = 1'b0;
        #1;
        n_checks++; if (Instr_Valid !== 1'b0 || Imem_PC !== 16'h0000 || Instr_PC !== 16'h0000) begin
            n_fail++; $display("FAIL rmid_async: got valid=%b imem_pc=%h pc=%h expected 0/0000/0000", Instr_Valid, Imem_PC, Instr_PC);
        end
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        model_reset();
        Redirect = 1'b1;
        Redirect_PC = 16'h0020;
        tick();
        Redirect = 1'b0;
        n_checks++; if (Imem_PC !== 16'h0000 || Instr_Valid !== 1'b0) begin n_fail++; $display("FAIL rmid_boot_redirect: got pc=%h valid=%b expected 0000/0", Imem_PC, Instr_Valid); end
        Instr_Ready = 1'b1;
        tick();
        n_checks++; if (Instr_PC !== 16'h0000) begin n_fail++; $display("FAIL rmid_restart0: got %h expected 0000", Instr_PC); end
        tick();
        n_checks++; if (Instr_PC !== 16'h0002) begin n_fail++; $display("FAIL rmid_restart1: got %h expected 0002", Instr_PC); end
    endtask

    task automatic test_back_to_back();
        logic        ev;
        logic [15:0] epc;
        logic [15:0] ein;
        do_reset();
        halt_on = 1'b1;
        halt_addr = 16'h0010;
        for (int i = 0; i < 600; i++) begin
            Instr_Ready = ($urandom_range(0, 3) != 0);
            Redirect = ($urandom_range(0, 15) == 0);
            Redirect_PC = ($urandom_range(0, 7) == 0) ? 16'hFFFC : 16'($urandom_range(0, 31) * 2);
            tick();
            ev  = (mq.size() != 0);
            epc = ev ? mq[0][15:0] : 16'h0000;
            ein = ev ? mq[0][31:16] : 16'h0000;
            n_checks++; if (Instr_Valid !== ev || Instr_PC !== epc || Instr !== ein) begin
                n_fail++; $display("FAIL rand_head[%0d]: got v=%b pc=%h in=%h expected v=%b pc=%h in=%h", i, Instr_Valid, Instr_PC, Instr, ev, epc, ein);
            end
            n_checks++; if (Imem_PC !== mpc) begin n_fail++; $display("FAIL rand_imem_pc[%0d]: got %h expected %h", i, Imem_PC, mpc); end
            n_checks++; if (Halted !== (mstate == 2 && mq.size() == 0)) begin n_fail++; $display("FAIL rand_halted[%0d]: got %b expected %b", i, Halted, (mstate == 2 && mq.size() == 0)); end
        end
        Redirect = 1'b0;
        halt_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
